eg_slot_sched: RTL and testbench
================================

// Module: eg_slot_sched
// PURPOSE
// - Time-multiplexed envelope scheduler: walks all operator slots, holds each slot's envelope phase,
//   derives the effective 6-bit rate and 3-bit counter phase, and drives the combinational step lookup.
// - Sits between the per-slot register file and the EG step/attenuation datapath; one slot per clk_en.
// PARAMETERS
// - SLOTS   24  operator slots served round-robin (>=2)
// - CNTW    15  width of global EG counter
// - EG_DIV  3   slot rounds per EG counter increment (>=1)
// PORTS
// - clk        in   1   system clock
// - rst_n      in   1   synchronous reset, active low
// - clk_en     in   1   slot advance enable; all state updates gated by it except reset
// - kon        in   1   key-on level for the current slot
// - ar         in   5   attack rate, current slot
// - d1r        in   5   decay-1 rate
// - d2r        in   5   decay-2 rate
// - rr         in   4   release rate
// - sl         in   4   sustain level
// - keycode    in   5   block/fnum key code
// - ks         in   2   key-scale
// - eg_level   in   10  current attenuation of current slot (0 = loudest)
// - step_V     in   1   step bit returned by step lookup for state_V/rate_V/cnt_V
// - slot       out  5   index of slot presented on state_V/rate_V/cnt_V
// - state_V    out  3   phase: ATTACK=0 DECAY1=1 DECAY2=2 RELEASE=7 (3 never produced)
// - rate_V     out  6   effective rate
// - cnt_V      out  3   counter phase for step selection
// - upd_V      out  1   counter-aligned update slot (step may be applied)
// - step_o     out  1   registered step_V & upd_V, one clk_en after presentation
// - step_slot  out  5   slot index matching step_o
// BEHAVIOUR
// - Reset (rst_n=0 on a clk edge, regardless of clk_en): all slots RELEASE, kon_prev=0, slot=0,
//   divider=0, eg_cnt=0; outputs slot=0, state_V=7, rate_V=0, cnt_V=0, upd_V=0, step_o=0, step_slot=0.
//   Reset mid-round discards all stored slot state; no partial update survives.
// - Slot counter: on clk_en, slot increments, SLOTS-1 wraps to 0. On wrap, divider increments;
//   divider==EG_DIV-1 at wrap -> divider=0, eg_cnt+=1 (modulo 2^CNTW), tick=1 for the following round.
// - Slot store: circular buffer of SLOTS entries {state[2:0], kon_prev}; read and write same slot per clk_en.
// - Next phase (priority high->low), computed from stored state and current inputs:
//   1 kon & !kon_prev -> ATTACK;  2 !kon & kon_prev -> RELEASE;
//   3 ATTACK & eg_level==0 -> DECAY1;
//   4 DECAY1 & eg_level[9:5] >= (sl==15 ? 5'h1f : {1'b0,sl}) -> DECAY2;  else hold.
//   kon_prev <= kon. Key edges override level transitions in the same slot.
// - Rate: R = ar/d1r/d2r/{rr,1'b1} by next phase; R==0 -> rate_V=0;
//   else rate_V = min(63, 2*R + (keycode >> (3-ks))), 7-bit intermediate, saturate.
// - Counter phase: shift = rate_V[5:2]>=11 ? 0 : 11-rate_V[5:2];
//   cnt_V = eg_cnt[shift+2:shift]; upd_V = tick & (shift==0 | eg_cnt[shift-1:0]==0).
// - Latency: slot/state_V/rate_V/cnt_V/upd_V registered, valid one clk_en after slot inputs sampled;
//   step_o/step_slot registered one further clk_en. Outputs hold while clk_en=0.
// - eg_cnt bits above CNTW-1 never indexed; shift+2 <= 13 requires CNTW >= 14.
// STRUCTURE
// - Package eg_pkg: phase localparams (ATTACK, DECAY1, DECAY2, RELEASE, HOLD), RATE_W=6, CNT_PH_W=3.
// - Sub-module eg_rate_calc (combinational): phase+rates+keycode+ks -> rate_V, shift.
// - Top: slot counter, divider/eg_cnt, slot store, phase FSM, output registers.
// TESTING
// - Reset: hold rst_n=0 2 clks with clk_en=1 -> state_V=7, rate_V=0, slot=0, step_o=0.
// - Key-on: slot 3 kon 0->1, ar=31, keycode=31, ks=3 -> state_V=0, rate_V=63 for slot 3.
// - Attack->decay: slot 3 ATTACK, eg_level=0, d1r=10, keycode=0, ks=0 -> next visit state_V=1, rate_V=20.
// - Sustain: DECAY1, sl=15, eg_level=10'h3e0 -> DECAY2; eg_level=10'h3df -> stays DECAY1.
// - Simultaneous: ATTACK with eg_level=0 and kon 1->0 same visit -> RELEASE, rate_V=2*{rr,1}.
// - Counter: EG_DIV=3, rate_V=44 (shift=0) -> upd_V=1 only in rounds after eg_cnt increments, once per 3 rounds.

Source files
------------

// File: rtl/eg_pkg.sv
// Shared envelope-generator encodings, widths and per-slot store entry.
package eg_pkg;

  localparam int unsigned RATE_W   = 6;
  localparam int unsigned CNT_PH_W = 3;
  localparam int unsigned PHASE_W  = 3;
  localparam int unsigned SLOT_W   = 5;
  localparam int unsigned SHIFT_W  = 4;
  localparam int unsigned LEVEL_W  = 10;

  localparam logic [PHASE_W-1:0] ATTACK  = 3'd0;
  localparam logic [PHASE_W-1:0] DECAY1  = 3'd1;
  localparam logic [PHASE_W-1:0] DECAY2  = 3'd2;
  localparam logic [PHASE_W-1:0] HOLD    = 3'd3;
  localparam logic [PHASE_W-1:0] RELEASE = 3'd7;

  typedef struct packed {
    logic [PHASE_W-1:0] phase;
    logic               kon_prev;
  } slot_ent_t;

  // Sustain threshold on eg_level[9:5]; sl==15 maps to the quietest step.
  function automatic logic [4:0] sus_thr(input logic [3:0] sl);
    return (sl == 4'hf) ? 5'h1f : {1'b0, sl};
  endfunction

endpackage

// File: rtl/eg_rate_calc.sv
// Effective envelope rate and counter shift for a given phase and key scaling.
module eg_rate_calc
  import eg_pkg::*;
(
  input  logic [PHASE_W-1:0] phase_i,
  input  logic [4:0]         ar_i,
  input  logic [4:0]         d1r_i,
  input  logic [4:0]         d2r_i,
  input  logic [3:0]         rr_i,
  input  logic [4:0]         keycode_i,
  input  logic [1:0]         ks_i,
  output logic [RATE_W-1:0]  rate_c,
  output logic [SHIFT_W-1:0] shift_c
);

  logic [4:0]        base;
  logic [4:0]        kc_sh;
  logic [6:0]        sum;
  logic [RATE_W-1:0] rate;

  always_comb begin
    base = 5'd0;
    case (phase_i)
      ATTACK:  base = ar_i;
      DECAY1:  base = d1r_i;
      DECAY2:  base = d2r_i;
      default: base = {rr_i, 1'b1};
    endcase

    kc_sh = keycode_i >> (2'd3 - ks_i);
    sum   = {1'b0, base, 1'b0} + {2'b00, kc_sh};

    // A zero programmed rate freezes the envelope regardless of key scaling.
    if (base == 5'd0) begin
      rate = '0;
    end else if (sum > 7'd63) begin
      rate = 6'd63;
    end else begin
      rate = sum[RATE_W-1:0];
    end

    rate_c  = rate;
    shift_c = (rate[5:2] >= 4'd11) ? 4'd0 : 4'd11 - rate[5:2];
  end

endmodule

// File: rtl/eg_slot_sched.sv
// Round-robin envelope scheduler: per-slot phase store, global EG counter and
// registered rate/counter-phase presentation for the step lookup.
module eg_slot_sched
  import eg_pkg::*;
#(
  parameter int unsigned SLOTS  = 24,
  parameter int unsigned CNTW   = 15,
  parameter int unsigned EG_DIV = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clk_en,
  input  logic                kon,
  input  logic [4:0]          ar,
  input  logic [4:0]          d1r,
  input  logic [4:0]          d2r,
  input  logic [3:0]          rr,
  input  logic [3:0]          sl,
  input  logic [4:0]          keycode,
  input  logic [1:0]          ks,
  input  logic [LEVEL_W-1:0]  eg_level,
  input  logic                step_V,
  output logic [SLOT_W-1:0]   slot,
  output logic [PHASE_W-1:0]  state_V,
  output logic [RATE_W-1:0]   rate_V,
  output logic [CNT_PH_W-1:0] cnt_V,
  output logic                upd_V,
  output logic                step_o,
  output logic [SLOT_W-1:0]   step_slot
);

  localparam int unsigned DIV_W = (EG_DIV > 1) ? $clog2(EG_DIV) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(EG_DIV - 1);

  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [CNTW-1:0]     eg_cnt_q, eg_cnt_d;
  logic                tick_q, tick_d;

  slot_ent_t           store_q [SLOTS];
  slot_ent_t           cur_ent;
  slot_ent_t           wr_ent;
  logic [PHASE_W-1:0]  phase_nx;

  logic [RATE_W-1:0]   rate_c;
  logic [SHIFT_W-1:0]  shift_c;
  logic [CNTW-1:0]     cnt_shr;
  logic [CNTW-1:0]     cnt_mask;
  logic [CNT_PH_W-1:0] cnt_ph_c;
  logic                upd_c;

  logic [SLOT_W-1:0]   pres_slot_q;
  logic [PHASE_W-1:0]  state_q;
  logic [RATE_W-1:0]   rate_q;
  logic [CNT_PH_W-1:0] cnt_q;
  logic                upd_q;
  logic                step_q;
  logic [SLOT_W-1:0]   step_slot_q;

  // Slot walk, round divider and global EG counter.
  always_comb begin
    slot_d   = slot_q;
    div_d    = div_q;
    eg_cnt_d = eg_cnt_q;
    tick_d   = tick_q;
    if (clk_en) begin
      if (slot_q == SLOT_LAST) begin
        slot_d = '0;
        if (div_q == DIV_LAST) begin
          div_d    = '0;
          eg_cnt_d = eg_cnt_q + CNTW'(1);
          tick_d   = 1'b1;
        end else begin
          div_d  = div_q + DIV_W'(1);
          tick_d = 1'b0;
        end
      end else begin
        slot_d = slot_q + SLOT_W'(1);
      end
    end
  end

  // Phase transitions; key edges take priority over level-driven moves.
  always_comb begin
    cur_ent  = store_q[slot_q];
    phase_nx = cur_ent.phase;
    if (kon && !cur_ent.kon_prev) begin
      phase_nx = ATTACK;
    end else if (!kon && cur_ent.kon_prev) begin
      phase_nx = RELEASE;
    end else if (cur_ent.phase == ATTACK && eg_level == '0) begin
      phase_nx = DECAY1;
    end else if (cur_ent.phase == DECAY1 && eg_level[9:5] >= sus_thr(sl)) begin
      phase_nx = DECAY2;
    end else if (cur_ent.phase == HOLD) begin
      phase_nx = RELEASE;
    end
    wr_ent.phase    = phase_nx;
    wr_ent.kon_prev = kon;
  end

  eg_rate_calc u_rate (
    .phase_i   (phase_nx),
    .ar_i      (ar),
    .d1r_i     (d1r),
    .d2r_i     (d2r),
    .rr_i      (rr),
    .keycode_i (keycode),
    .ks_i      (ks),
    .rate_c    (rate_c),
    .shift_c   (shift_c)
  );

  // Counter phase window and rate-aligned update qualifier.
  always_comb begin
    cnt_shr  = eg_cnt_q >> shift_c;
    cnt_ph_c = cnt_shr[CNT_PH_W-1:0];
    cnt_mask = (CNTW'(1) << shift_c) - CNTW'(1);
    upd_c    = tick_q & ((eg_cnt_q & cnt_mask) == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q   <= '0;
      div_q    <= '0;
      eg_cnt_q <= '0;
      tick_q   <= 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
        store_q[i] <= '{phase: RELEASE, kon_prev: 1'b0};
      end
    end else begin
      slot_q   <= slot_d;
      div_q    <= div_d;
      eg_cnt_q <= eg_cnt_d;
      tick_q   <= tick_d;
      if (clk_en) begin
        store_q[slot_q] <= wr_ent;
      end
    end
  end

  // Presentation stage followed by the step-capture stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pres_slot_q <= '0;
      state_q     <= RELEASE;
      rate_q      <= '0;
      cnt_q       <= '0;
      upd_q       <= 1'b0;
      step_q      <= 1'b0;
      step_slot_q <= '0;
    end else if (clk_en) begin
      pres_slot_q <= slot_q;
      state_q     <= phase_nx;
      rate_q      <= rate_c;
      cnt_q       <= cnt_ph_c;
      upd_q       <= upd_c;
      step_q      <= step_V & upd_q;
      step_slot_q <= pres_slot_q;
    end
  end

  assign slot      = pres_slot_q;
  assign state_V   = state_q;
  assign rate_V    = rate_q;
  assign cnt_V     = cnt_q;
  assign upd_V     = upd_q;
  assign step_o    = step_q;
  assign step_slot = step_slot_q;

endmodule

// File: tb/tb_eg_slot_sched.sv
// Randomized scoreboard bench for eg_slot_sched against a round/visit-count reference model.
module tb_eg_slot_sched;

  localparam int SLOTS  = 24;
  localparam int CNTW   = 15;
  localparam int EG_DIV = 3;
  localparam int NCYC   = 4000;

  logic       clk = 1'b0;
  logic       rst_n, clk_en, kon, step_V;
  logic [4:0] ar, d1r, d2r, keycode;
  logic [3:0] rr, sl;
  logic [1:0] ks;
  logic [9:0] eg_level;
  logic [4:0] slot, step_slot;
  logic [2:0] state_V, cnt_V;
  logic [5:0] rate_V;
  logic       upd_V, step_o;

  eg_slot_sched #(.SLOTS(SLOTS), .CNTW(CNTW), .EG_DIV(EG_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .kon(kon),
    .ar(ar), .d1r(d1r), .d2r(d2r), .rr(rr), .sl(sl),
    .keycode(keycode), .ks(ks), .eg_level(eg_level), .step_V(step_V),
    .slot(slot), .state_V(state_V), .rate_V(rate_V), .cnt_V(cnt_V),
    .upd_V(upd_V), .step_o(step_o), .step_slot(step_slot)
  );

  always #5 clk = ~clk;

  typedef struct {
    int slot; int state; int rate; int cnt; int upd; int step; int step_slot;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  int m_ph [SLOTS];
  int m_kp [SLOTS];
  int m_n;
  int m_prev_upd, m_prev_slot;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int rate_of(input int ph, input int a, input int d1, input int d2,
                                 input int r, input int kc, input int k);
    int base, v;
    case (ph)
      0: base = a;
      1: base = d1;
      2: base = d2;
      default: base = r * 2 + 1;
    endcase
    if (base == 0) return 0;
    v = 2 * base + kc / (1 << (3 - k));
    return (v > 63) ? 63 : v;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < SLOTS; s++) begin
      m_ph[s] = 7;
      m_kp[s] = 0;
    end
    m_n = 0;
    m_prev_upd = 0;
    m_prev_slot = 0;
    sb_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    clk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_slot", 32'(slot), 0);
    chk("rst_state", 32'(state_V), 7);
    chk("rst_rate", 32'(rate_V), 0);
    chk("rst_cnt", 32'(cnt_V), 0);
    chk("rst_upd", 32'(upd_V), 0);
    chk("rst_step", 32'(step_o), 0);
    chk("rst_step_slot", 32'(step_slot), 0);
    rst_n = 1'b1;
    clk_en = 1'b0;
  endtask

  // Drive one cycle of random slot inputs; on clk_en, predict the presentation.
  task automatic drive_cycle();
    int s, r, kp, ph, nx, thr, rt, sh, egc, tick;
    exp_t e;
    @(posedge clk); #1;
    s = m_n % SLOTS;
    r = m_n / SLOTS;
    clk_en   = ($urandom_range(3) != 0);
    kon      = ($urandom_range(7) == 0) ? (m_kp[s] == 0) : (m_kp[s] != 0);
    ar       = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
    d1r      = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
    d2r      = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
    rr       = 4'($urandom_range(15));
    sl       = ($urandom_range(1) == 0) ? 4'hf : 4'($urandom_range(15));
    keycode  = 5'($urandom_range(31));
    ks       = 2'($urandom_range(3));
    step_V   = 1'($urandom_range(1));
    case ($urandom_range(5))
      0: eg_level = 10'h000;
      1: eg_level = 10'h3e0;
      2: eg_level = 10'h3df;
      3: eg_level = {sl, 1'b0, 5'h00};
      4: eg_level = 10'({sl, 5'h00}) - 10'd1;
      default: eg_level = 10'($urandom_range(1023));
    endcase
    if (clk_en) begin
      kp = m_kp[s];
      ph = m_ph[s];
      thr = (sl == 4'hf) ? 31 : int'(sl);
      if (kon && kp == 0) nx = 0;
      else if (!kon && kp != 0) nx = 7;
      else if (ph == 0 && eg_level == 0) nx = 1;
      else if (ph == 1 && int'(eg_level) / 32 >= thr) nx = 2;
      else nx = ph;
      rt   = rate_of(nx, int'(ar), int'(d1r), int'(d2r), int'(rr), int'(keycode), int'(ks));
      sh   = (rt / 4 >= 11) ? 0 : 11 - rt / 4;
      egc  = (r / EG_DIV) % (1 << CNTW);
      tick = (r > 0 && r % EG_DIV == 0) ? 1 : 0;
      e.slot      = s;
      e.state     = nx;
      e.rate      = rt;
      e.cnt       = (egc / (1 << sh)) % 8;
      e.upd       = (tick != 0 && egc % (1 << sh) == 0) ? 1 : 0;
      e.step      = int'(step_V) & m_prev_upd;
      e.step_slot = m_prev_slot;
      sb_q.push_back(e);
      m_ph[s] = nx;
      m_kp[s] = kon ? 1 : 0;
      m_prev_upd = e.upd;
      m_prev_slot = s;
      m_n++;
    end
  endtask

  // Monitor: every enabled, non-reset edge must present the oldest prediction.
  initial begin
    logic en, rn;
    exp_t e;
    forever begin
      @(posedge clk);
      en = clk_en;
      rn = rst_n;
      #1;
      if (rn === 1'b1 && en === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 32'd1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("slot", 32'(slot), e.slot);
          chk("state_V", 32'(state_V), e.state);
          chk("rate_V", 32'(rate_V), e.rate);
          chk("cnt_V", 32'(cnt_V), e.cnt);
          chk("upd_V", 32'(upd_V), e.upd);
          chk("step_o", 32'(step_o), e.step);
          chk("step_slot", 32'(step_slot), e.step_slot);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b1; clk_en = 1'b0; kon = 1'b0; step_V = 1'b0;
    ar = '0; d1r = '0; d2r = '0; rr = '0; sl = '0;
    keycode = '0; ks = '0; eg_level = '0;
    model_reset();
    do_reset();
    repeat (NCYC) drive_cycle();
    do_reset();
    repeat (NCYC) drive_cycle();
    @(posedge clk); #1;
    clk_en = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("sb_drain", 32'(sb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
